// File: rtl/top_lib.sv
// Shared types and register map for the info register bank.
// Register addresses are word addresses on the host control bus.
package top_lib;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0]   sreg;
    typedef logic [2*MAX_W-1:0] dreg;

    localparam int ADDR_MAGIC        = 0;
    localparam int ADDR_MAJ_VER      = 1;
    localparam int ADDR_MIN_VER      = 2;
    localparam int ADDR_GIT_HSH      = 3;
    localparam int ADDR_UPTIME_LO    = 4;
    localparam int ADDR_UPTIME_HI    = 5;
    localparam int ADDR_CONFIG       = 6;
    localparam int ADDR_RESERVED     = 7;
    localparam int ADDR_SCRATCH_BASE = 8;

    typedef enum logic {IDLE, RESP} bank_state_t;

endpackage

// File: rtl/info_reg_bank_uptime_counter.sv
// Free-running uptime counter; wraps from all-ones back to zero.
module uptime_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clkIn,
    input  logic             rstIn,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/info_reg_bank.sv
// Identification and scratch register bank with a single-outstanding
// request/response handshake and a coherent double-width uptime counter.
module info_reg_bank
    import top_lib::*;
#(
    parameter int  DATA_W      = 32,
    parameter int  ADDR_W      = 6,
    parameter int  NUM_SCRATCH = 4,
    parameter sreg MAJ_VER     = '0,
    parameter sreg MIN_VER     = '0,
    parameter sreg GIT_HSH     = '0,
    parameter sreg MAGIC       = sreg'(32'h534E4553)
) (
    input  logic              clkIn,
    input  logic              rstIn,
    input  logic              reqValidIn,
    output logic              reqReadyOut,
    input  logic              reqWriteIn,
    input  logic [ADDR_W-1:0] reqAddrIn,
    input  logic [DATA_W-1:0] reqDataIn,
    output logic              rspValidOut,
    input  logic              rspReadyIn,
    output logic [DATA_W-1:0] rspDataOut,
    output logic              rspErrOut
);

    localparam logic [DATA_W-1:0] MAGIC_W   = MAGIC[DATA_W-1:0];
    localparam logic [DATA_W-1:0] MAJ_VER_W = MAJ_VER[DATA_W-1:0];
    localparam logic [DATA_W-1:0] MIN_VER_W = MIN_VER[DATA_W-1:0];
    localparam logic [DATA_W-1:0] GIT_HSH_W = GIT_HSH[DATA_W-1:0];
    localparam sreg               CFG_FULL  = sreg'({8'(DATA_W), 8'(NUM_SCRATCH)});
    localparam logic [DATA_W-1:0] CFG_W     = CFG_FULL[DATA_W-1:0];

    bank_state_t         state;
    bank_state_t         stateNext;
    logic [2*DATA_W-1:0] uptime;
    logic [DATA_W-1:0]   uptimeSnap;
    logic [DATA_W-1:0]   scratch [NUM_SCRATCH];
    logic [31:0]         addrWord;
    logic                accept;
    logic                rspDone;
    logic                scratchHit;
    logic                decodeErr;
    logic [DATA_W-1:0]   readData;
    logic                reqReadyNext;
    logic                rspValidNext;
    logic [DATA_W-1:0]   rspDataNext;
    logic                rspErrNext;

    assign addrWord = 32'(reqAddrIn);
    assign accept   = reqValidIn && reqReadyOut;
    assign rspDone  = rspValidOut && rspReadyIn;

    uptime_counter #(
        .WIDTH(2*DATA_W)
    ) u_uptime (
        .clkIn (clkIn),
        .rstIn (rstIn),
        .count (uptime)
    );

    // Writes are only legal to scratch; reads are legal to 0..6 and scratch.
    always_comb begin
        readData   = '0;
        scratchHit = 1'b0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (addrWord == 32'(ADDR_SCRATCH_BASE + i)) begin
                scratchHit = 1'b1;
                readData   = scratch[i];
            end
        end
        case (addrWord)
            32'(ADDR_MAGIC):     readData = MAGIC_W;
            32'(ADDR_MAJ_VER):   readData = MAJ_VER_W;
            32'(ADDR_MIN_VER):   readData = MIN_VER_W;
            32'(ADDR_GIT_HSH):   readData = GIT_HSH_W;
            32'(ADDR_UPTIME_LO): readData = uptime[DATA_W-1:0];
            32'(ADDR_UPTIME_HI): readData = uptimeSnap;
            32'(ADDR_CONFIG):    readData = CFG_W;
            default: ;
        endcase
        decodeErr = !(scratchHit || (!reqWriteIn && addrWord <= 32'(ADDR_CONFIG)));
    end

    always_comb begin
        stateNext    = state;
        reqReadyNext = reqReadyOut;
        rspValidNext = rspValidOut;
        rspDataNext  = rspDataOut;
        rspErrNext   = rspErrOut;
        case (state)
            IDLE: begin
                reqReadyNext = 1'b1;
                if (accept) begin
                    stateNext    = RESP;
                    reqReadyNext = 1'b0;
                    rspValidNext = 1'b1;
                    rspErrNext   = decodeErr;
                    rspDataNext  = (decodeErr || reqWriteIn) ? '0 : readData;
                end
            end
            RESP: begin
                if (rspDone) begin
                    stateNext    = IDLE;
                    reqReadyNext = 1'b1;
                    rspValidNext = 1'b0;
                    rspDataNext  = '0;
                    rspErrNext   = 1'b0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state       <= IDLE;
            reqReadyOut <= 1'b0;
            rspValidOut <= 1'b0;
            rspDataOut  <= '0;
            rspErrOut   <= 1'b0;
        end else begin
            state       <= stateNext;
            reqReadyOut <= reqReadyNext;
            rspValidOut <= rspValidNext;
            rspDataOut  <= rspDataNext;
            rspErrOut   <= rspErrNext;
        end
    end

    // Reading UPTIME_LO freezes the matching high half so a following
    // UPTIME_HI read forms a coherent pair even across a low-half wrap.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            uptimeSnap <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
        end else if (accept) begin
            if (!reqWriteIn && addrWord == 32'(ADDR_UPTIME_LO)) begin
                uptimeSnap <= uptime[2*DATA_W-1:DATA_W];
            end
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (reqWriteIn && addrWord == 32'(ADDR_SCRATCH_BASE + i)) begin
                    scratch[i] <= reqDataIn;
                end
            end
        end
    end

endmodule

// File: tb/tb_info_reg_bank.sv
// Directed bench for info_reg_bank: a 32-bit bank for the register map and
// handshake, plus a 16-bit bank to exercise the uptime low-half wrap.
module tb_info_reg_bank;

    logic        clk;
    logic        rst;
    logic        reqValid [2];
    logic        reqWrite [2];
    logic        rspReady [2];
    logic [5:0]  reqAddr  [2];
    logic [31:0] reqData  [2];
    logic        reqReady [2];
    logic        rspValid [2];
    logic        rspErr   [2];
    logic [31:0] bigData;
    logic [15:0] smallData;

    int     nTests;
    int     nFail;
    longint edgeCnt;

    typedef struct {
        string       name;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs [18];

    info_reg_bank #(
        .DATA_W(32), .ADDR_W(6), .NUM_SCRATCH(4),
        .MAJ_VER(2), .MIN_VER(5), .GIT_HSH(32'h1234ABCD), .MAGIC(32'h534E4553)
    ) dut (
        .clkIn(clk), .rstIn(rst),
        .reqValidIn(reqValid[0]), .reqReadyOut(reqReady[0]),
        .reqWriteIn(reqWrite[0]), .reqAddrIn(reqAddr[0]), .reqDataIn(reqData[0]),
        .rspValidOut(rspValid[0]), .rspReadyIn(rspReady[0]),
        .rspDataOut(bigData), .rspErrOut(rspErr[0])
    );

    info_reg_bank #(
        .DATA_W(16), .ADDR_W(6), .NUM_SCRATCH(2),
        .MAJ_VER(2), .MIN_VER(5), .GIT_HSH(32'h1234ABCD), .MAGIC(32'h534E4553)
    ) dutSmall (
        .clkIn(clk), .rstIn(rst),
        .reqValidIn(reqValid[1]), .reqReadyOut(reqReady[1]),
        .reqWriteIn(reqWrite[1]), .reqAddrIn(reqAddr[1]), .reqDataIn(reqData[1][15:0]),
        .rspValidOut(rspValid[1]), .rspReadyIn(rspReady[1]),
        .rspDataOut(smallData), .rspErrOut(rspErr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference uptime: edges seen since reset released.
    always @(posedge clk or posedge rst) begin
        if (rst) edgeCnt <= 0;
        else     edgeCnt <= edgeCnt + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rspDataOf(input int inst);
        return (inst == 0) ? bigData : {16'h0, smallData};
    endfunction

    task automatic applyStimulus(input int inst, input logic wr, input logic [5:0] addr,
                                 input logic [31:0] data, output logic [31:0] rdata,
                                 output logic err, output longint acceptCnt);
        int n;
        n = 0;
        rdata = '0;
        err = 1'b0;
        acceptCnt = 0;
        @(negedge clk);
        while (!reqReady[inst] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!reqReady[inst]) begin
            checkOutput("ready timeout", 32'(reqReady[inst]), 32'd1);
            return;
        end
        reqValid[inst] = 1'b1;
        reqWrite[inst] = wr;
        reqAddr[inst]  = addr;
        reqData[inst]  = data;
        acceptCnt      = edgeCnt;
        @(posedge clk);
        #1;
        reqValid[inst] = 1'b0;
        checkOutput("rsp valid after accept", 32'(rspValid[inst]), 32'd1);
        checkOutput("ready low after accept", 32'(reqReady[inst]), 32'd0);
        rdata = rspDataOf(inst);
        err   = rspErr[inst];
        rspReady[inst] = 1'b1;
        @(posedge clk);
        #1;
        rspReady[inst] = 1'b0;
        checkOutput("rsp valid after handshake", 32'(rspValid[inst]), 32'd0);
        checkOutput("ready after handshake", 32'(reqReady[inst]), 32'd1);
    endtask

    task automatic addVec(input int i, input string name, input logic wr, input logic [5:0] addr,
                          input logic [31:0] data, input logic [31:0] expData, input logic expErr);
        vecs[i].name    = name;
        vecs[i].wr      = wr;
        vecs[i].addr    = addr;
        vecs[i].data    = data;
        vecs[i].expData = expData;
        vecs[i].expErr  = expErr;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        longint      ac;
        logic [31:0] lo1, hi1, lo2, hi2;
        longint      ac1, ac2;

        nTests = 0;
        nFail  = 0;
        rst    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            reqValid[k] = 1'b0;
            reqWrite[k] = 1'b0;
            rspReady[k] = 1'b0;
            reqAddr[k]  = '0;
            reqData[k]  = '0;
        end

        addVec(0,  "rd magic",        1'b0, 6'd0,  32'h0,        32'h534E4553, 1'b0);
        addVec(1,  "rd maj",          1'b0, 6'd1,  32'h0,        32'd2,        1'b0);
        addVec(2,  "rd min",          1'b0, 6'd2,  32'h0,        32'd5,        1'b0);
        addVec(3,  "rd hash",         1'b0, 6'd3,  32'h0,        32'h1234ABCD, 1'b0);
        addVec(4,  "rd config",       1'b0, 6'd6,  32'h0,        32'h00002004, 1'b0);
        addVec(5,  "rd hi pre-snap",  1'b0, 6'd5,  32'h0,        32'h0,        1'b0);
        addVec(6,  "wr s8",           1'b1, 6'd8,  32'hDEADBEEF, 32'h0,        1'b0);
        addVec(7,  "rd s8",           1'b0, 6'd8,  32'h0,        32'hDEADBEEF, 1'b0);
        addVec(8,  "rd s9",           1'b0, 6'd9,  32'h0,        32'h0,        1'b0);
        addVec(9,  "wr s11",          1'b1, 6'd11, 32'hA5A50F0F, 32'h0,        1'b0);
        addVec(10, "rd s11",          1'b0, 6'd11, 32'h0,        32'hA5A50F0F, 1'b0);
        addVec(11, "wr ro addr1",     1'b1, 6'd1,  32'hFFFFFFFF, 32'h0,        1'b1);
        addVec(12, "rd reserved 7",   1'b0, 6'd7,  32'h0,        32'h0,        1'b1);
        addVec(13, "rd beyond 12",    1'b0, 6'd12, 32'h0,        32'h0,        1'b1);
        addVec(14, "wr beyond 12",    1'b1, 6'd12, 32'h12345678, 32'h0,        1'b1);
        addVec(15, "wr ro uptime",    1'b1, 6'd4,  32'h55555555, 32'h0,        1'b1);
        addVec(16, "rd maj again",    1'b0, 6'd1,  32'h0,        32'd2,        1'b0);
        addVec(17, "rd s10",          1'b0, 6'd10, 32'h0,        32'h0,        1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("ready in reset", 32'(reqReady[0]), 32'd0);
        checkOutput("rsp valid in reset", 32'(rspValid[0]), 32'd0);
        checkOutput("rsp data in reset", bigData, 32'h0);
        checkOutput("rsp err in reset", 32'(rspErr[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready before first edge", 32'(reqReady[0]), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ready after first edge", 32'(reqReady[0]), 32'd1);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(0, vecs[i].wr, vecs[i].addr, vecs[i].data, rd, er, ac);
            checkOutput({vecs[i].name, " data"}, rd, vecs[i].expData);
            checkOutput({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].expErr));
        end

        // Uptime pair at small counts: LO equals count at accept, HI snapshot is 0.
        applyStimulus(0, 1'b0, 6'd4, 32'h0, lo1, er, ac1);
        checkOutput("uptime lo", lo1, ac1[31:0]);
        applyStimulus(0, 1'b0, 6'd5, 32'h0, hi1, er, ac);
        checkOutput("uptime hi", hi1, ac1[63:32]);

        // Response held for 5 cycles; a second request during that time is ignored.
        @(negedge clk);
        checkOutput("ready before hold", 32'(reqReady[0]), 32'd1);
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b0;
        reqAddr[0]  = 6'd8;
        @(posedge clk);
        #1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 6'd9;
        reqData[0]  = 32'h11111111;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput("hold valid", 32'(rspValid[0]), 32'd1);
            checkOutput("hold data", bigData, 32'hDEADBEEF);
            checkOutput("hold err", 32'(rspErr[0]), 32'd0);
            checkOutput("hold ready", 32'(reqReady[0]), 32'd0);
        end
        reqValid[0] = 1'b0;
        reqWrite[0] = 1'b0;
        rspReady[0] = 1'b1;
        @(posedge clk);
        #1;
        rspReady[0] = 1'b0;
        applyStimulus(0, 1'b0, 6'd9, 32'h0, rd, er, ac);
        checkOutput("ignored write s9", rd, 32'h0);

        // 16-bit bank: truncated magic, config word, range errors, scratch width.
        applyStimulus(1, 1'b0, 6'd0, 32'h0, rd, er, ac);
        checkOutput("small magic", rd, 32'h00004553);
        applyStimulus(1, 1'b0, 6'd6, 32'h0, rd, er, ac);
        checkOutput("small config", rd, 32'h00001002);
        applyStimulus(1, 1'b0, 6'd10, 32'h0, rd, er, ac);
        checkOutput("small beyond err", 32'(er), 32'd1);
        checkOutput("small beyond data", rd, 32'h0);
        applyStimulus(1, 1'b1, 6'd9, 32'h0000BEEF, rd, er, ac);
        applyStimulus(1, 1'b0, 6'd9, 32'h0, rd, er, ac);
        checkOutput("small s9", rd, 32'h0000BEEF);

        // Uptime pairs straddling the 16-bit low-half wrap.
        while (edgeCnt < 65528) @(negedge clk);
        applyStimulus(1, 1'b0, 6'd4, 32'h0, lo1, er, ac1);
        applyStimulus(1, 1'b0, 6'd5, 32'h0, hi1, er, ac);
        checkOutput("wrap lo before", lo1, {16'h0, ac1[15:0]});
        checkOutput("wrap hi before", hi1, {16'h0, ac1[31:16]});
        while (edgeCnt < 65540) @(negedge clk);
        applyStimulus(1, 1'b0, 6'd4, 32'h0, lo2, er, ac2);
        applyStimulus(1, 1'b0, 6'd5, 32'h0, hi2, er, ac);
        checkOutput("wrap lo after", lo2, {16'h0, ac2[15:0]});
        checkOutput("wrap hi after", hi2, 32'h1);
        checkOutput("wrap monotonic", 32'({hi2[15:0], lo2[15:0]} > {hi1[15:0], lo1[15:0]}), 32'd1);

        // Reset asserted while a response is pending.
        @(negedge clk);
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b0;
        reqAddr[0]  = 6'd8;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        checkOutput("pre-reset valid", 32'(rspValid[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid reset valid", 32'(rspValid[0]), 32'd0);
        checkOutput("mid reset ready", 32'(reqReady[0]), 32'd0);
        checkOutput("mid reset data", bigData, 32'h0);
        checkOutput("mid reset err", 32'(rspErr[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 6'd8, 32'h0, rd, er, ac);
        checkOutput("post reset s8", rd, 32'h0);
        applyStimulus(0, 1'b0, 6'd11, 32'h0, rd, er, ac);
        checkOutput("post reset s11", rd, 32'h0);
        applyStimulus(0, 1'b0, 6'd4, 32'h0, rd, er, ac);
        checkOutput("post reset uptime", rd, ac[31:0]);
        applyStimulus(1, 1'b0, 6'd9, 32'h0, rd, er, ac);
        checkOutput("post reset small s9", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/info_reg_bank.md
# info_reg_bank

Parametrised identification and scratch register bank answering single-beat register requests from the host-side control bus. Returns a magic word, version fields, a build configuration word and a coherent 2×DATA_W free-running uptime counter, plus NUM_SCRATCH read/write scratch registers. It sits behind the top-level control decoder and replaces the fixed, read-only version-register set with a generalised, bus-accessible bank.

## Interface
- DATA_W, 32: register width; legal range 16..64.
- ADDR_W, 6: word-address width.
- NUM_SCRATCH, 4: scratch register count; legal range 1..(2^ADDR_W − 8).
- MAJ_VER, 0: major version; zero-extended or truncated to DATA_W.
- MIN_VER, 0: minor version; same width rule as MAJ_VER.
- GIT_HSH, 0: build git hash; same width rule as MAJ_VER.
- MAGIC, 32'h534E4553: identification word; same width rule as MAJ_VER.

Ports:
- clkIn  in  1  single clock; all logic is on the rising edge.
- rstIn  in  1  asynchronous, active-high reset.
- reqValidIn  in  1  request valid.
- reqReadyOut  out  1  request ready.
- reqWriteIn  in  1  1 = write, 0 = read.
- reqAddrIn  in  ADDR_W  word address.
- reqDataIn  in  DATA_W  write data.
- rspValidOut  out  1  response valid.
- rspReadyIn  in  1  response ready.
- rspDataOut  out  DATA_W  read data; 0 for writes and errors.
- rspErrOut  out  1  address decode or access error.

## Operation
- Register map:
  - 0 MAGIC (RO)
  - 1 MAJ_VER (RO)
  - 2 MIN_VER (RO)
  - 3 GIT_HSH (RO)
  - 4 UPTIME_LO (RO)
  - 5 UPTIME_HI (RO, snapshot)
  - 6 CONFIG (RO): bits [7:0] = NUM_SCRATCH, bits [15:8] = DATA_W, upper bits 0
  - 7 reserved
  - 8..8+NUM_SCRATCH−1 SCRATCH (RW)
- Error responses (rspErrOut = 1, rspDataOut = 0, no state change):
  - any access to address 7 or above the last scratch register;
  - a write to addresses 0..6.
- State machine:
  - IDLE → RESP on accept (reqValidIn && reqReadyOut).
  - RESP → IDLE on rspValidOut && rspReadyIn.
  - Only one transaction is outstanding at a time.
- Uptime counter:
  - 2×DATA_W bits, increments every clock and wraps from all-ones to 0.
  - A read of UPTIME_LO returns the low half at the accept cycle and, on the same edge, captures the high half into the snapshot register.
  - UPTIME_HI returns the snapshot, never the live value. The snapshot is 0 until the first UPTIME_LO read.
- Scratch writes commit on the accept edge. A read in the next transaction returns the new value.
- Reset (asynchronous, including mid-transaction):
  - reqReadyOut, rspValidOut, rspDataOut, rspErrOut → 0.
  - Any pending response is dropped.
  - State → IDLE; uptime, snapshot and all scratch registers → 0.

## Timing
- reqReadyOut is registered. It is 0 during reset and rises on the first clock edge after rstIn deasserts.
- Accept at edge N:
  - rspValidOut = 1 after edge N, with data and error valid.
  - reqReadyOut = 0 after edge N.
- rspValidOut, rspDataOut and rspErrOut stay stable while rspReadyIn = 0.
- Response handshake at edge M:
  - rspValidOut = 0 and reqReadyOut = 1 after edge M.
  - The next accept can occur at edge M+1.
- Latency: request to response is 1 cycle. Maximum throughput is one transaction per 2 cycles.
- reqValidIn asserted while reqReadyOut = 0 is ignored; requesters hold their request until accepted.
- The uptime value returned equals the count at the accept edge.

## Structure
- Shared package top_lib holds:
  - typedefs sreg and dreg;
  - register address constants (ADDR_MAGIC … ADDR_SCRATCH_BASE);
  - the bank state enum {IDLE, RESP}.
- Sub-module uptime_counter (parameter WIDTH): a 2×DATA_W counter with clock, reset and count output. Snapshot logic stays in info_reg_bank.

## Test plan
- Release reset; read addresses 0..3 with MAJ_VER=2, MIN_VER=5 → 32'h534E4553, 2, 5, GIT_HSH; rspErrOut = 0 for each.
- Write 32'hDEADBEEF to address 8, then read address 8 → 32'hDEADBEEF. Read address 9 → 0.
- Preload the uptime counter near 32'hFFFFFFFF, then read UPTIME_LO then UPTIME_HI across the low-half wrap → the 64-bit pair is monotonic and consistent with the accept cycle.
- Error cases, each returning rspErrOut = 1 and rspDataOut = 0:
  - write address 1;
  - read address 7;
  - read address 12 with NUM_SCRATCH=4.
  - Then read address 1 → MAJ_VER unchanged.
- Hold rspReadyIn = 0 for 5 cycles → response stable, reqReadyOut = 0 throughout; a second reqValidIn during this time is ignored.
- Assert rstIn while rspValidOut = 1 → outputs 0 immediately. After release, the scratch registers and the uptime count read 0 (plus elapsed cycles for uptime).
